alu_rs: RTL and testbench



---
 rtl/alu_rs.sv | 182 ++++++++++++++++++
 tb/tb_alu_rs.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_rs.sv
// Reservation station for the integer ALU/branch unit: holds dispatched ops until both
// operands are captured from the CDBs, then issues the lowest-index ready entry.
module alu_rs #(
   parameter int unsigned ENTRIES = 8,
   parameter int unsigned ROB_W   = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr_i,
   input  logic             disp_en_i,
   input  logic [6:0]       disp_op_i,
   input  logic [6:0]       disp_funct7_i,
   input  logic [2:0]       disp_funct3_i,
   input  logic [31:0]      disp_imm_i,
   input  logic [31:0]      disp_pc_i,
   input  logic [ROB_W-1:0] disp_rob_i,
   input  logic             disp_rj_i,
   input  logic [31:0]      disp_vj_i,
   input  logic [ROB_W-1:0] disp_qj_i,
   input  logic             disp_rk_i,
   input  logic [31:0]      disp_vk_i,
   input  logic [ROB_W-1:0] disp_qk_i,
   input  logic             cdb0_en_i,
   input  logic [ROB_W-1:0] cdb0_id_i,
   input  logic [31:0]      cdb0_data_i,
   input  logic             cdb1_en_i,
   input  logic [ROB_W-1:0] cdb1_id_i,
   input  logic [31:0]      cdb1_data_i,
   output logic             full_o,
   output logic             ex_en_o,
   output logic [31:0]      ex_A_o,
   output logic [31:0]      ex_B_o,
   output logic [31:0]      ex_imm_o,
   output logic [31:0]      ex_pc_o,
   output logic [6:0]       ex_op_o,
   output logic [6:0]       ex_funct7_o,
   output logic [2:0]       ex_funct3_o,
   output logic [ROB_W-1:0] ex_rob_o
);

   localparam int unsigned IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

   logic [ENTRIES-1:0] valid_q;
   logic [6:0]         op_q     [ENTRIES];
   logic [6:0]         funct7_q [ENTRIES];
   logic [2:0]         funct3_q [ENTRIES];
   logic [31:0]        imm_q    [ENTRIES];
   logic [31:0]        pc_q     [ENTRIES];
   logic [ROB_W-1:0]   rob_q    [ENTRIES];
   logic               rj_q     [ENTRIES];
   logic [31:0]        vj_q     [ENTRIES];
   logic [ROB_W-1:0]   qj_q     [ENTRIES];
   logic               rk_q     [ENTRIES];
   logic [31:0]        vk_q     [ENTRIES];
   logic [ROB_W-1:0]   qk_q     [ENTRIES];

   logic             free_found, iss_found, disp_ok;
   logic [IDX_W-1:0] free_idx, iss_idx;
   logic             rj_in, rk_in;
   logic [31:0]      vj_in, vk_in;

   assign full_o  = &valid_q;
   assign disp_ok = disp_en_i && !full_o;

   // Lowest free slot for dispatch and lowest ready slot for issue, from registered state
   always_comb begin
      free_found = 1'b0;
      free_idx   = '0;
      iss_found  = 1'b0;
      iss_idx    = '0;
      for (int i = 0; i < int'(ENTRIES); i++) begin
         if (!free_found && !valid_q[IDX_W'(i)]) begin
            free_found = 1'b1;
            free_idx   = IDX_W'(i);
         end
         if (!iss_found && valid_q[IDX_W'(i)] && rj_q[IDX_W'(i)] && rk_q[IDX_W'(i)]) begin
            iss_found = 1'b1;
            iss_idx   = IDX_W'(i);
         end
      end
   end

   // Dispatch bypass: an operand broadcast in the dispatch cycle is captured directly
   always_comb begin
      rj_in = disp_rj_i;
      vj_in = disp_vj_i;
      rk_in = disp_rk_i;
      vk_in = disp_vk_i;
      if (!disp_rj_i) begin
         if (cdb0_en_i && cdb0_id_i == disp_qj_i) begin
            rj_in = 1'b1;
            vj_in = cdb0_data_i;
         end else if (cdb1_en_i && cdb1_id_i == disp_qj_i) begin
            rj_in = 1'b1;
            vj_in = cdb1_data_i;
         end
      end
      if (!disp_rk_i) begin
         if (cdb0_en_i && cdb0_id_i == disp_qk_i) begin
            rk_in = 1'b1;
            vk_in = cdb0_data_i;
         end else if (cdb1_en_i && cdb1_id_i == disp_qk_i) begin
            rk_in = 1'b1;
            vk_in = cdb1_data_i;
         end
      end
   end

   // Occupancy and issue register
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q     <= '0;
         ex_en_o     <= 1'b0;
         ex_A_o      <= '0;
         ex_B_o      <= '0;
         ex_imm_o    <= '0;
         ex_pc_o     <= '0;
         ex_op_o     <= '0;
         ex_funct7_o <= '0;
         ex_funct3_o <= '0;
         ex_rob_o    <= '0;
      end else if (clr_i) begin
         valid_q <= '0;
         ex_en_o <= 1'b0;
      end else begin
         ex_en_o <= iss_found;
         if (iss_found) begin
            ex_A_o             <= vj_q[iss_idx];
            ex_B_o             <= vk_q[iss_idx];
            ex_imm_o           <= imm_q[iss_idx];
            ex_pc_o            <= pc_q[iss_idx];
            ex_op_o            <= op_q[iss_idx];
            ex_funct7_o        <= funct7_q[iss_idx];
            ex_funct3_o        <= funct3_q[iss_idx];
            ex_rob_o           <= rob_q[iss_idx];
            valid_q[iss_idx]   <= 1'b0;
         end
         if (disp_ok) valid_q[free_idx] <= 1'b1;
      end
   end

   // Entry payload: CDB wakeup on waiting operands (cdb0 has priority), dispatch fill of a free slot
   always_ff @(posedge clk) begin
      if (!rst && !clr_i) begin
         for (int i = 0; i < int'(ENTRIES); i++) begin
            if (valid_q[IDX_W'(i)] && !rj_q[IDX_W'(i)]) begin
               if (cdb0_en_i && cdb0_id_i == qj_q[IDX_W'(i)]) begin
                  rj_q[IDX_W'(i)] <= 1'b1;
                  vj_q[IDX_W'(i)] <= cdb0_data_i;
               end else if (cdb1_en_i && cdb1_id_i == qj_q[IDX_W'(i)]) begin
                  rj_q[IDX_W'(i)] <= 1'b1;
                  vj_q[IDX_W'(i)] <= cdb1_data_i;
               end
            end
            if (valid_q[IDX_W'(i)] && !rk_q[IDX_W'(i)]) begin
               if (cdb0_en_i && cdb0_id_i == qk_q[IDX_W'(i)]) begin
                  rk_q[IDX_W'(i)] <= 1'b1;
                  vk_q[IDX_W'(i)] <= cdb0_data_i;
               end else if (cdb1_en_i && cdb1_id_i == qk_q[IDX_W'(i)]) begin
                  rk_q[IDX_W'(i)] <= 1'b1;
                  vk_q[IDX_W'(i)] <= cdb1_data_i;
               end
            end
         end
         if (disp_ok) begin
            op_q[free_idx]     <= disp_op_i;
            funct7_q[free_idx] <= disp_funct7_i;
            funct3_q[free_idx] <= disp_funct3_i;
            imm_q[free_idx]    <= disp_imm_i;
            pc_q[free_idx]     <= disp_pc_i;
            rob_q[free_idx]    <= disp_rob_i;
            rj_q[free_idx]     <= rj_in;
            vj_q[free_idx]     <= vj_in;
            qj_q[free_idx]     <= disp_qj_i;
            rk_q[free_idx]     <= rk_in;
            vk_q[free_idx]     <= vk_in;
            qk_q[free_idx]     <= disp_qk_i;
         end
      end
   end

endmodule

// File: tb/tb_alu_rs.sv
// Bench for alu_rs: dispatch vectors with a scoreboard of expected issues, plus
// hand-written sequences for wakeup timing, full station, ordering and flush.
module tb_alu_rs;
   localparam int unsigned ENTRIES = 8;
   localparam int unsigned ROB_W   = 5;

   logic             clk = 1'b0;
   logic             rst, clr_i, disp_en_i;
   logic [6:0]       disp_op_i, disp_funct7_i;
   logic [2:0]       disp_funct3_i;
   logic [31:0]      disp_imm_i, disp_pc_i, disp_vj_i, disp_vk_i;
   logic [ROB_W-1:0] disp_rob_i, disp_qj_i, disp_qk_i;
   logic             disp_rj_i, disp_rk_i;
   logic             cdb0_en_i, cdb1_en_i;
   logic [ROB_W-1:0] cdb0_id_i, cdb1_id_i;
   logic [31:0]      cdb0_data_i, cdb1_data_i;
   logic             full_o, ex_en_o;
   logic [31:0]      ex_A_o, ex_B_o, ex_imm_o, ex_pc_o;
   logic [6:0]       ex_op_o, ex_funct7_o;
   logic [2:0]       ex_funct3_o;
   logic [ROB_W-1:0] ex_rob_o;

   always #5 clk = ~clk;

   alu_rs #(.ENTRIES(ENTRIES), .ROB_W(ROB_W)) dut (
      .clk(clk), .rst(rst), .clr_i(clr_i), .disp_en_i(disp_en_i),
      .disp_op_i(disp_op_i), .disp_funct7_i(disp_funct7_i), .disp_funct3_i(disp_funct3_i),
      .disp_imm_i(disp_imm_i), .disp_pc_i(disp_pc_i), .disp_rob_i(disp_rob_i),
      .disp_rj_i(disp_rj_i), .disp_vj_i(disp_vj_i), .disp_qj_i(disp_qj_i),
      .disp_rk_i(disp_rk_i), .disp_vk_i(disp_vk_i), .disp_qk_i(disp_qk_i),
      .cdb0_en_i(cdb0_en_i), .cdb0_id_i(cdb0_id_i), .cdb0_data_i(cdb0_data_i),
      .cdb1_en_i(cdb1_en_i), .cdb1_id_i(cdb1_id_i), .cdb1_data_i(cdb1_data_i),
      .full_o(full_o), .ex_en_o(ex_en_o), .ex_A_o(ex_A_o), .ex_B_o(ex_B_o),
      .ex_imm_o(ex_imm_o), .ex_pc_o(ex_pc_o), .ex_op_o(ex_op_o),
      .ex_funct7_o(ex_funct7_o), .ex_funct3_o(ex_funct3_o), .ex_rob_o(ex_rob_o)
   );

   typedef struct packed {
      logic [31:0]      a, b, imm, pc;
      logic [6:0]       op, f7;
      logic [2:0]       f3;
      logic [ROB_W-1:0] rob;
   } exp_t;

   typedef struct packed {
      logic             rj;
      logic [31:0]      vj;
      logic [ROB_W-1:0] qj;
      logic             rk;
      logic [31:0]      vk;
      logic [ROB_W-1:0] qk;
      logic             c0en;
      logic [ROB_W-1:0] c0id;
      logic [31:0]      c0d;
      logic             c1en;
      logic [ROB_W-1:0] c1id;
      logic [31:0]      c1d;
      logic [31:0]      ea, eb;
   } vec_t;

   exp_t sb[$];
   exp_t mon_e, mon_g;
   int   n_vec = 0;
   int   n_err = 0;
   vec_t vecs[7];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Every issue pulse must match the oldest outstanding expectation
   always @(negedge clk) begin
      if (ex_en_o === 1'b1) begin
         n_vec++;
         if (sb.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_issue: rob %0d issued, none expected", ex_rob_o);
         end else begin
            mon_e = sb.pop_front();
            mon_g = '{a: ex_A_o, b: ex_B_o, imm: ex_imm_o, pc: ex_pc_o, op: ex_op_o,
                      f7: ex_funct7_o, f3: ex_funct3_o, rob: ex_rob_o};
            if (mon_g !== mon_e) begin
               n_err++;
               $display("FAIL issue_payload: got %h expected %h", mon_g, mon_e);
            end
         end
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
      disp_en_i = 1'b0;
      cdb0_en_i = 1'b0;
      cdb1_en_i = 1'b0;
      clr_i     = 1'b0;
   endtask

   // Dispatch with payload fields derived from the rob tag so each issue is identifiable
   task automatic dq(input logic [ROB_W-1:0] rob, input logic rj, input logic [31:0] vj,
                     input logic [ROB_W-1:0] qj, input logic rk, input logic [31:0] vk,
                     input logic [ROB_W-1:0] qk);
      disp_en_i     = 1'b1;
      disp_op_i     = 7'b0110011;
      disp_funct7_i = {2'b0, rob};
      disp_funct3_i = rob[2:0];
      disp_imm_i    = 32'(rob) * 32'd3;
      disp_pc_i     = 32'h100 + 32'(rob) * 32'd4;
      disp_rob_i    = rob;
      disp_rj_i = rj; disp_vj_i = vj; disp_qj_i = qj;
      disp_rk_i = rk; disp_vk_i = vk; disp_qk_i = qk;
   endtask

   task automatic expect_issue(input logic [ROB_W-1:0] rob, input logic [31:0] a,
                               input logic [31:0] b);
      exp_t e;
      e = '{a: a, b: b, imm: 32'(rob) * 32'd3, pc: 32'h100 + 32'(rob) * 32'd4,
            op: 7'b0110011, f7: {2'b0, rob}, f3: rob[2:0], rob: rob};
      sb.push_back(e);
   endtask

   task automatic cdb0(input logic [ROB_W-1:0] id, input logic [31:0] d);
      cdb0_en_i = 1'b1; cdb0_id_i = id; cdb0_data_i = d;
   endtask

   task automatic cdb1(input logic [ROB_W-1:0] id, input logic [31:0] d);
      cdb1_en_i = 1'b1; cdb1_id_i = id; cdb1_data_i = d;
   endtask

   initial begin
      // rj, vj, qj, rk, vk, qk, cdb0 {en,id,data}, cdb1 {en,id,data}, expected A, B
      vecs[0] = '{1'b1, 32'hdeadbeef, 5'd0, 1'b1, 32'h1, 5'd0,
                  1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 32'hdeadbeef, 32'h1};
      vecs[1] = '{1'b0, 32'h0, 5'd4, 1'b1, 32'h9, 5'd0,
                  1'b1, 5'd4, 32'h1234, 1'b0, 5'd0, 32'h0, 32'h1234, 32'h9};
      vecs[2] = '{1'b1, 32'h3, 5'd0, 1'b0, 32'h0, 5'd6,
                  1'b0, 5'd0, 32'h0, 1'b1, 5'd6, 32'hab, 32'h3, 32'hab};
      vecs[3] = '{1'b0, 32'h0, 5'd7, 1'b0, 32'h0, 5'd7,
                  1'b1, 5'd7, 32'h111, 1'b1, 5'd7, 32'h222, 32'h111, 32'h111};
      vecs[4] = '{1'b0, 32'h0, 5'd2, 1'b0, 32'h0, 5'd3,
                  1'b1, 5'd3, 32'h66, 1'b1, 5'd2, 32'h55, 32'h55, 32'h66};
      vecs[5] = '{1'b1, 32'h10, 5'd1, 1'b1, 32'h20, 5'd1,
                  1'b1, 5'd1, 32'hff, 1'b0, 5'd0, 32'h0, 32'h10, 32'h20};
      vecs[6] = '{1'b0, 32'h0, 5'd8, 1'b1, 32'h0, 5'd0,
                  1'b1, 5'd9, 32'h1, 1'b1, 5'd8, 32'h2, 32'h2, 32'h0};

      rst = 1'b1; clr_i = 1'b0; disp_en_i = 1'b0; cdb0_en_i = 1'b0; cdb1_en_i = 1'b0;
      disp_op_i = '0; disp_funct7_i = '0; disp_funct3_i = '0; disp_imm_i = '0; disp_pc_i = '0;
      disp_rob_i = '0; disp_rj_i = 1'b0; disp_vj_i = '0; disp_qj_i = '0;
      disp_rk_i = 1'b0; disp_vk_i = '0; disp_qk_i = '0;
      cdb0_id_i = '0; cdb0_data_i = '0; cdb1_id_i = '0; cdb1_data_i = '0;
      tick; tick;
      chk("rst_ex_en", 32'(ex_en_o), 32'd0);
      chk("rst_full", 32'(full_o), 32'd0);
      chk("rst_ex_a", ex_A_o, 32'd0);
      chk("rst_ex_rob", 32'(ex_rob_o), 32'd0);
      rst = 1'b0;
      tick;

      // Basic ready dispatch: issue one edge after the dispatch edge, single-cycle pulse
      dq(5'd3, 1'b1, 32'd5, 5'd0, 1'b1, 32'd7, 5'd0);
      expect_issue(5'd3, 32'd5, 32'd7);
      tick;
      chk("t1_no_early_issue", 32'(ex_en_o), 32'd0);
      tick;
      chk("t1_issue", 32'(ex_en_o), 32'd1);
      tick;
      chk("t1_pulse_end", 32'(ex_en_o), 32'd0);
      chk("t1_a_hold", ex_A_o, 32'd5);

      // Vector table: dispatch with concurrent CDB traffic (bypass, priority, ignore cases)
      for (int i = 0; i < 7; i++) begin
         dq(5'(16 + i), vecs[i].rj, vecs[i].vj, vecs[i].qj, vecs[i].rk, vecs[i].vk, vecs[i].qk);
         if (vecs[i].c0en) cdb0(vecs[i].c0id, vecs[i].c0d);
         if (vecs[i].c1en) cdb1(vecs[i].c1id, vecs[i].c1d);
         expect_issue(5'(16 + i), vecs[i].ea, vecs[i].eb);
         tick;
         chk("vec_no_early_issue", 32'(ex_en_o), 32'd0);
         tick;
         chk("vec_issue", 32'(ex_en_o), 32'd1);
      end
      tick;

      // Wakeup after dispatch: no same-edge wake and issue
      dq(5'd1, 1'b0, 32'd0, 5'd4, 1'b1, 32'd2, 5'd0);
      expect_issue(5'd1, 32'h10, 32'd2);
      tick; tick;
      chk("wake_wait", 32'(ex_en_o), 32'd0);
      cdb0(5'd4, 32'h10);
      tick;
      chk("wake_no_same_edge", 32'(ex_en_o), 32'd0);
      tick;
      chk("wake_issue", 32'(ex_en_o), 32'd1);
      chk("wake_a", ex_A_o, 32'h10);

      // Both operands wake on the same edge from different CDBs
      dq(5'd2, 1'b0, 32'd0, 5'd11, 1'b0, 32'd0, 5'd12);
      expect_issue(5'd2, 32'h77, 32'h88);
      tick;
      cdb0(5'd11, 32'h77); cdb1(5'd12, 32'h88);
      tick; tick;
      chk("dual_wake_issue", 32'(ex_en_o), 32'd1);
      tick;

      // Fill all entries waiting on tag 9, overflow dispatch dropped, then drain in order
      for (int i = 0; i < 8; i++) begin
         dq(5'(i), 1'b0, 32'd0, 5'd9, 1'b1, 32'(i), 5'd0);
         tick;
      end
      chk("full_set", 32'(full_o), 32'd1);
      dq(5'd20, 1'b1, 32'd1, 5'd0, 1'b1, 32'd1, 5'd0);
      tick;
      chk("full_hold", 32'(full_o), 32'd1);
      chk("full_no_issue", 32'(ex_en_o), 32'd0);
      for (int i = 0; i < 8; i++) expect_issue(5'(i), 32'h99, 32'(i));
      cdb0(5'd9, 32'h99);
      tick;
      chk("full_wake_no_issue", 32'(ex_en_o), 32'd0);
      chk("full_wake_still_full", 32'(full_o), 32'd1);
      for (int i = 0; i < 8; i++) begin
         tick;
         chk("drain_issue", 32'(ex_en_o), 32'd1);
         chk("drain_order", 32'(ex_rob_o), 32'(i));
         if (i == 0) chk("full_drop", 32'(full_o), 32'd0);
      end
      tick;
      chk("drain_done", 32'(ex_en_o), 32'd0);

      // Entries 2 and 5 become ready together: lower index issues first
      for (int i = 0; i < 6; i++) begin
         dq(5'(10 + i), 1'b0, 32'd0, (i == 2 || i == 5) ? 5'd21 : 5'd20, 1'b1, 32'd0, 5'd0);
         tick;
      end
      expect_issue(5'd12, 32'h21, 32'd0);
      expect_issue(5'd15, 32'h21, 32'd0);
      cdb0(5'd21, 32'h21);
      tick;
      chk("pair_no_same_edge", 32'(ex_en_o), 32'd0);
      tick;
      chk("pair_first", 32'(ex_rob_o), 32'd12);
      tick;
      chk("pair_second", 32'(ex_rob_o), 32'd15);
      tick;
      chk("pair_done", 32'(ex_en_o), 32'd0);
      clr_i = 1'b1;
      tick;
      chk("flush1_full", 32'(full_o), 32'd0);

      // Flush with a ready entry pending, concurrent dispatch and CDB all discarded
      dq(5'd24, 1'b0, 32'd0, 5'd22, 1'b1, 32'd0, 5'd0); tick;
      dq(5'd25, 1'b0, 32'd0, 5'd23, 1'b1, 32'd0, 5'd0); tick;
      dq(5'd26, 1'b1, 32'd4, 5'd0, 1'b1, 32'd4, 5'd0); tick;
      chk("flush_pre", 32'(ex_en_o), 32'd0);
      clr_i = 1'b1;
      dq(5'd27, 1'b1, 32'd1, 5'd0, 1'b1, 32'd1, 5'd0);
      cdb0(5'd22, 32'h5);
      tick;
      chk("flush_ex_en", 32'(ex_en_o), 32'd0);
      chk("flush_full", 32'(full_o), 32'd0);
      tick;
      chk("flush_disp_dropped", 32'(ex_en_o), 32'd0);
      cdb0(5'd22, 32'h5); cdb1(5'd23, 32'h6);
      tick; tick;
      chk("flush_stale_wake", 32'(ex_en_o), 32'd0);
      tick;
      chk("sb_empty", 32'(sb.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
